// File: rtl/unified_mem_responder.sv
// Single-port word memory answering one request at a time after WAIT_STATES extra cycles.
// Optional: define MEM_BOUNDS_CHECK_EN to fault aligned requests at or above 4*DEPTH_WORDS.
module unified_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          acc_write;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_be;
    logic [AW-1:0] acc_idx;
    logic          acc_fault;
    logic          mem_we;

    logic [31:0]   mem [DEPTH_WORDS];

    // With zero wait states the access happens on the accepting edge, so it uses the live request.
    always_comb begin
        acc_write = (state_q == ST_IDLE) ? req_write : write_q;
        acc_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
        acc_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
        acc_be    = (state_q == ST_IDLE) ? req_be    : be_q;
    end

    assign acc_idx = acc_addr[AW+1:2];

`ifdef MEM_BOUNDS_CHECK_EN
    assign acc_fault = (acc_addr[1:0] != 2'b00) || (acc_addr[31:AW+2] != '0);
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^acc_addr[31:AW+2];
    assign acc_fault      = (acc_addr[1:0] != 2'b00);
`endif

    // NOTE: every signal driven here gets a default first; a path that skips one would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = '0;
        err_d   = 1'b0;
        mem_we  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = ST_RESP;
            end
            ST_RESP: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // The edge that enters RESP performs the access and registers the response.
        if (state_d == ST_RESP && state_q != ST_RESP) begin
            if (acc_fault)       err_d   = 1'b1;
            else if (!acc_write) rdata_d = mem[acc_idx];
            else                 mem_we  = rstn;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the array has no reset; its contents must survive rstn, and a reset would stop RAM inference.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_unified_mem_responder.sv
// Directed bench: a WAIT_STATES=2 instance driven from a vector table plus reset and
// back-to-back corner sequences on a WAIT_STATES=0 instance.
module tb_unified_mem_responder;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid = 1'b0, z_req_write = 1'b0;
    logic [31:0] z_req_addr = '0, z_req_wdata = '0;
    logic [3:0]  z_req_be = '0;
    logic        z_req_ready, z_rsp_valid, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    unified_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    unified_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rstn(rstn),
        .req_valid(z_req_valid), .req_write(z_req_write), .req_addr(z_req_addr),
        .req_wdata(z_req_wdata), .req_be(z_req_be), .req_ready(z_req_ready),
        .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns the response and its latency in edges
    // counted from (and including) the accepting edge, or -1 if no response arrived.
    task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, output logic [31:0] rd, output logic er,
                          output int lat);
        rd = '0; er = 1'b0; lat = -1;
        check("ready_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_be = be;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("ready_low_after_accept", 32'(req_ready), 32'd0);
        for (int n = 0; n < 40; n++) begin
            if (rsp_valid) begin
                rd = rsp_rdata; er = rsp_err; lat = n + 1;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) begin
            check("rsp_timeout", 32'd0, 32'd1);
        end else begin
            @(negedge clk);
            check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
        end
    endtask

    vec_t        vecs [15];
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        saw_rsp;

    initial begin
        vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h20,   32'h11223344, 4'hF, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 32'h20,   32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 32'h20,   32'h0,        4'h0, 32'h11BB33DD, 1'b0};
        vecs[5]  = '{1'b0, 32'h22,   32'h0,        4'h0, 32'h0,        1'b1};
        vecs[6]  = '{1'b0, 32'h20,   32'h0,        4'h0, 32'h11BB33DD, 1'b0};
        vecs[7]  = '{1'b1, 32'h23,   32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        vecs[8]  = '{1'b0, 32'h20,   32'h0,        4'h0, 32'h11BB33DD, 1'b0};
        vecs[9]  = '{1'b1, 32'h20,   32'h00000000, 4'h0, 32'h0,        1'b0};
        vecs[10] = '{1'b0, 32'h20,   32'h0,        4'h0, 32'h11BB33DD, 1'b0};
        vecs[11] = '{1'b1, 32'h4,    32'h01010101, 4'hF, 32'h0,        1'b0};
        vecs[12] = '{1'b1, 32'h1004, 32'h5A5A5A5A, 4'hF, 32'h0,        1'b0};
        vecs[13] = '{1'b0, 32'h4,    32'h0,        4'h0, 32'h5A5A5A5A, 1'b0};
        vecs[14] = '{1'b1, 32'h30,   32'hCAFEF00D, 4'hF, 32'h0,        1'b0};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);

        foreach (vecs[i]) begin
            do_req(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
        end

        // Reset during WAIT discards the pending store and its response
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h12345678; req_be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rstn = 1'b0;
        #2;
        check("wait_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        saw_rsp = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            saw_rsp |= rsp_valid;
        end
        check("wait_rst_no_rsp", 32'(saw_rsp), 32'd0);
        check("wait_rst_ready", 32'(req_ready), 32'd1);
        do_req(1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
        check("wait_rst_load_rdata", rd, 32'hCAFEF00D);
        check("wait_rst_load_err", 32'(er), 32'd0);

        // WAIT_STATES=0 with req_valid held: accept every second cycle, response right after
        z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = 32'h8;
        z_req_wdata = 32'h77665544; z_req_be = 4'hF;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("b2b%0d_ready", i), 32'(z_req_ready), 32'((i % 2) == 0));
            check($sformatf("b2b%0d_rsp_valid", i), 32'(z_rsp_valid), 32'((i % 2) == 1));
            @(negedge clk);
        end
        z_req_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        z_req_valid = 1'b0;
        check("ws0_load_valid", 32'(z_rsp_valid), 32'd1);
        check("ws0_load_rdata", z_rsp_rdata, 32'h77665544);
        check("ws0_load_err", 32'(z_rsp_err), 32'd0);
        @(negedge clk);
        check("ws0_idle_rdata", z_rsp_rdata, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
